disp_scan_mux: RTL and testbench



---
 rtl/disp_scan_mux.sv | 133 +++++++++++++
 tb/tb_disp_scan_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: prescaled 7-segment anode scanner that shows one debug channel word per frame.
// Optional leading-zero blanking is built when DISP_LZB_EN is defined.
module disp_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_CH     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int SELW       = 2
) (
  input  logic                            myCLK,
  input  logic                            Reset,
  input  logic [SELW-1:0]                 SW,
  input  logic [NUM_CH*4*NUM_DIGITS-1:0]  ch_data,
  input  logic                            hold,
  output logic [NUM_DIGITS-1:0]           AN,
  output logic [6:0]                      SEG,
  output logic [3:0]                      store
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [W-1:0]          r_snap;
  logic                  r_active;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [3:0]            r_store;

  logic                  w_tick;
  logic                  w_frame_start;
  logic [W-1:0]          w_ch [NUM_CH];
  logic [W-1:0]          w_sel_word;
  logic [3:0]            w_nib;
  logic [NUM_DIGITS-1:0] w_an_lit;
  logic                  w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch[gi] = ch_data[gi*W +: W];
    end
  endgenerate

  // Out-of-range selects fall through to an all-zero word.
  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SW == SELW'(k)) begin
        w_sel_word = w_ch[k];
      end
    end
  end

  assign w_tick        = (r_presc == PRESC_MAX);
  assign w_frame_start = w_tick && (r_idx == IDX_MAX);
  assign w_nib         = r_snap[4*r_idx +: 4];
  assign w_an_lit      = ~(NUM_DIGITS'(1) << r_idx);

`ifdef DISP_LZB_EN
  logic [NUM_DIGITS-1:0] w_upper_zero;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      assign w_upper_zero[gi] = ~|r_snap[W-1:4*gi];
    end
  endgenerate
  assign w_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge myCLK or posedge Reset) begin
    if (Reset) begin
      r_presc  <= '0;
      r_idx    <= IDX_MAX;
      r_snap   <= '0;
      r_active <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx    <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        r_active <= 1'b1;
      end
      // Snapshot only at frame start so a frame never mixes two words.
      if (w_frame_start && !hold) begin
        r_snap <= w_sel_word;
      end
    end
  end

  always_ff @(posedge myCLK or posedge Reset) begin
    if (Reset) begin
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_store <= '0;
    end else begin
      r_store <= w_nib;
      r_an    <= (r_active && !w_blank) ? w_an_lit : '1;
      r_seg   <= (r_active && !w_blank) ? hex7(w_nib) : 7'h7F;
    end
  end

  assign AN    = r_an;
  assign SEG   = r_seg;
  assign store = r_store;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed scoreboard bench for disp_scan_mux (4 digits, 3 channels, 4-cycle scan).
// Expected digit slots are queued when the frame-determining stimulus is driven.
module tb_disp_scan_mux;

  logic        clk;
  logic        rst;
  logic [1:0]  sw;
  logic        hold;
  logic [15:0] ch0, ch1, ch2;
  logic [47:0] ch_data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [3:0]  store;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] st;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign ch_data = {ch2, ch1, ch0};

  disp_scan_mux #(
    .NUM_DIGITS(4),
    .NUM_CH    (3),
    .SCAN_DIV  (4),
    .SELW      (2)
  ) dut (
    .myCLK  (clk),
    .Reset  (rst),
    .SW     (sw),
    .ch_data(ch_data),
    .hold   (hold),
    .AN     (an),
    .SEG    (seg),
    .store  (store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic push_frame(input logic [15:0] word);
    exp_t e;
    logic blank;
    for (int d = 0; d < 4; d++) begin
      e.st  = word[4*d +: 4];
      blank = 1'b0;
`ifdef DISP_LZB_EN
      blank = (d > 0) && ((word >> (4*d)) == 16'h0);
`endif
      e.an  = blank ? 4'hF : ~(4'b0001 << d);
      e.seg = blank ? 7'h7F : seg_of(e.st);
      q.push_back(e);
    end
  endtask

  task automatic check_one(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic [3:0] e_st);
    check_one({tag, ".AN"}, {4'h0, an}, {4'h0, e_an});
    check_one({tag, ".SEG"}, {1'b0, seg}, {1'b0, e_seg});
    check_one({tag, ".store"}, {4'h0, store}, {4'h0, e_st});
  endtask

  task automatic check_slot(input string tag);
    exp_t e;
    n_cmp++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check_out(tag, e.an, e.seg, e.st);
    end
  endtask

  task automatic advance();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    sw   = 2'd0;
    hold = 1'b0;
    ch0  = 16'h1234;
    ch1  = 16'hABCD;
    ch2  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_init", 4'hF, 7'h7F, 4'h0);

    // First run up to digit 2, then an asynchronous reset mid-scan.
    @(negedge clk);
    rst = 1'b0;
    push_frame(ch0);
    repeat (4) @(posedge clk);
    #1;
    check_out("pre_tick0", 4'hF, 7'h7F, 4'h0);
    @(posedge clk);
    #1;
    check_slot("R0"); advance();
    check_slot("R1"); advance();
    check_slot("R2");
    rst = 1'b1;
    #1;
    check_out("reset_async", 4'hF, 7'h7F, 4'h0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_held", 4'hF, 7'h7F, 4'h0);

    @(negedge clk);
    rst = 1'b0;
    push_frame(ch0);
    repeat (4) @(posedge clk);
    #1;
    check_out("pre_tick1", 4'hF, 7'h7F, 4'h0);
    @(posedge clk);
    #1;

    // Frame A: 1234; SW switches while digit 1 lit.
    check_slot("A0"); advance();
    check_slot("A1");
    sw = 2'd1;
    push_frame(ch1);
    advance();
    check_slot("A2"); advance();
    check_slot("A3"); advance();

    // Frame B: ABCD; switch back to channel 0.
    check_slot("B0"); advance();
    check_slot("B1");
    sw = 2'd0;
    push_frame(ch0);
    advance();
    check_slot("B2"); advance();
    check_slot("B3"); advance();

    // Frame C: 1234; freeze and change channel 0.
    check_slot("C0"); advance();
    check_slot("C1"); advance();
    check_slot("C2");
    hold = 1'b1;
    ch0  = 16'h5678;
    push_frame(16'h1234);
    advance();
    check_slot("C3"); advance();

    // Frame D: held 1234; release hold.
    check_slot("D0"); advance();
    check_slot("D1"); advance();
    check_slot("D2");
    hold = 1'b0;
    push_frame(ch0);
    advance();
    check_slot("D3"); advance();

    // Frame E: 5678; select out-of-range channel.
    check_slot("E0"); advance();
    check_slot("E1");
    sw = 2'd3;
    push_frame(16'h0000);
    advance();
    check_slot("E2"); advance();
    check_slot("E3"); advance();

    // Frame F: zero word; select channel 2 holding 0045.
    check_slot("F0"); advance();
    check_slot("F1");
    sw  = 2'd2;
    ch2 = 16'h0045;
    push_frame(ch2);
    advance();
    check_slot("F2"); advance();
    check_slot("F3"); advance();

    // Frame G: 0045; mid-frame data change must not tear.
    check_slot("G0"); advance();
    check_slot("G1");
    ch2 = 16'h9E0F;
    advance();
    check_slot("G2"); advance();
    check_slot("G3");

    // hold rises just before the frame-start edge and must win.
    repeat (2) @(posedge clk);
    @(negedge clk);
    hold = 1'b1;
    push_frame(16'h0045);
    @(posedge clk);
    @(posedge clk);
    #1;

    // Frame H: still 0045; release hold so the next frame reloads.
    check_slot("H0");
    hold = 1'b0;
    push_frame(ch2);
    advance();
    check_slot("H1"); advance();
    check_slot("H2"); advance();
    check_slot("H3"); advance();

    // Frame I: 9E0F.
    check_slot("I0"); advance();
    check_slot("I1"); advance();
    check_slot("I2"); advance();
    check_slot("I3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
